// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU. Each port gets a
// one-deep registered response slot; one operation is accepted per cycle.
module alu_arbiter #(
    parameter int WORD_SIZE     = 32,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [3:0]           req0_op,
    input  logic [WORD_SIZE-1:0] req0_a,
    input  logic [WORD_SIZE-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [3:0]           req1_op,
    input  logic [WORD_SIZE-1:0] req1_a,
    input  logic [WORD_SIZE-1:0] req1_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [WORD_SIZE-1:0] rsp0_result,
    output logic                 rsp0_zero,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [WORD_SIZE-1:0] rsp1_result,
    output logic                 rsp1_zero,
    output logic [3:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic                 alu_zero
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // req*_ready is the grant; rsp*_ready feeds req*_ready combinationally so a
    // full slot being drained can accept a new operation in the same cycle.

    logic                 rsp0_valid_q, rsp0_valid_d;
    logic                 rsp1_valid_q, rsp1_valid_d;
    logic [WORD_SIZE-1:0] rsp0_result_q, rsp0_result_d;
    logic [WORD_SIZE-1:0] rsp1_result_q, rsp1_result_d;
    logic                 rsp0_zero_q, rsp0_zero_d;
    logic                 rsp1_zero_q, rsp1_zero_d;
    logic                 last_grant_q, last_grant_d;

    logic elig0, elig1, grant0, grant1;

    always_comb begin
        // Gating with rst_n keeps both readies low while reset is held.
        elig0  = rst_n && req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1  = rst_n && req1_valid && (!rsp1_valid_q || rsp1_ready);
        grant0 = elig0 && (!elig1 || (PRIORITY_MODE != 0) || last_grant_q);
        grant1 = elig1 && !grant0;

        alu_op = 4'd0;
        alu_a  = '0;
        alu_b  = '0;
        if (grant0) begin
            alu_op = req0_op;
            alu_a  = req0_a;
            alu_b  = req0_b;
        end else if (grant1) begin
            alu_op = req1_op;
            alu_a  = req1_a;
            alu_b  = req1_b;
        end

        rsp0_valid_d  = rsp0_valid_q && !rsp0_ready;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_valid_d  = rsp1_valid_q && !rsp1_ready;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;
        last_grant_d  = last_grant_q;

        if (grant0) begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = alu_result;
            rsp0_zero_d   = alu_zero;
            last_grant_d  = 1'b0;
        end
        if (grant1) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = alu_result;
            rsp1_zero_d   = alu_zero;
            last_grant_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_zero_q   <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_zero_q   <= rsp1_zero_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance
// share stimulus, each with its own behavioural ALU.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic         req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [3:0]   req0_op = 0, req1_op = 0;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;

    logic         rr_req0_ready, rr_req1_ready, rr_rsp0_valid, rr_rsp1_valid;
    logic [W-1:0] rr_rsp0_result, rr_rsp1_result, rr_alu_a, rr_alu_b, rr_alu_result;
    logic         rr_rsp0_zero, rr_rsp1_zero, rr_alu_zero;
    logic [3:0]   rr_alu_op;
    logic         fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic [W-1:0] fp_rsp0_result, fp_rsp1_result, fp_alu_a, fp_alu_b, fp_alu_result;
    logic         fp_rsp0_zero, fp_rsp1_zero, fp_alu_zero;
    logic [3:0]   fp_alu_op;

    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(W-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

    assign rr_alu_result = alu_f(rr_alu_op, rr_alu_a, rr_alu_b);
    assign rr_alu_zero   = (rr_alu_result == '0);
    assign fp_alu_result = alu_f(fp_alu_op, fp_alu_a, fp_alu_b);
    assign fp_alu_zero   = (fp_alu_result == '0);

    always #5 clk = ~clk;

    alu_arbiter #(.WORD_SIZE(W), .PRIORITY_MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rr_rsp0_result), .rsp0_zero(rr_rsp0_zero),
        .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rr_rsp1_result), .rsp1_zero(rr_rsp1_zero),
        .alu_op(rr_alu_op), .alu_a(rr_alu_a), .alu_b(rr_alu_b),
        .alu_result(rr_alu_result), .alu_zero(rr_alu_zero)
    );

    alu_arbiter #(.WORD_SIZE(W), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(fp_rsp0_result), .rsp0_zero(fp_rsp0_zero),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(fp_rsp1_result), .rsp1_zero(fp_rsp1_zero),
        .alu_op(fp_alu_op), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
        .alu_result(fp_alu_result), .alu_zero(fp_alu_zero)
    );

    // Inputs change 1 time unit after a rising edge; checks happen before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_op = 0; req1_op = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        req0_valid = 1; req0_op = OP_ADD; req0_a = 4; req0_b = 4; rsp0_ready = 0;
        tick();
        req0_valid = 1; req1_valid = 1;
        req0_op = OP_ADD; req0_a = 1; req0_b = 1;
        req1_op = OP_ADD; req1_a = 2; req1_b = 2;
        #1 rst_n = 0;
        #1;
        checks++;
        if (rr_rsp0_valid !== 1'b0 || rr_rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b%b exp 00", rr_rsp0_valid, rr_rsp1_valid);
        end
        checks++;
        if (rr_rsp0_result !== '0 || rr_rsp0_zero !== 1'b0 || rr_rsp1_result !== '0) begin
            errors++; $display("FAIL reset_result got %0h/%b/%0h exp 0/0/0",
                               rr_rsp0_result, rr_rsp0_zero, rr_rsp1_result);
        end
        checks++;
        if (rr_req0_ready !== 1'b0 || rr_req1_ready !== 1'b0 || fp_req0_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b%b%b exp 000",
                               rr_req0_ready, rr_req1_ready, fp_req0_ready);
        end
        tick();
        rsp0_ready = 1;
        rst_n = 1;
        #1;
        checks++;
        if (rr_req0_ready !== 1'b1 || rr_req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_first_grant got %b%b exp 10", rr_req0_ready, rr_req1_ready);
        end
        tick();
        checks++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp0_result !== 32'd2 || rr_rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_first_rsp got v%b r%0d v1=%b exp v1 r2 v1=0",
                               rr_rsp0_valid, rr_rsp0_result, rr_rsp1_valid);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req0_valid = 1; req0_op = OP_ADD; req0_a = 5; req0_b = 7;
        #1;
        checks++;
        if (rr_req0_ready !== 1'b1 || rr_alu_a !== 32'd5 || rr_alu_b !== 32'd7) begin
            errors++; $display("FAIL single_accept got rdy%b a%0d b%0d exp rdy1 a5 b7",
                               rr_req0_ready, rr_alu_a, rr_alu_b);
        end
        tick();
        req0_valid = 0;
        #1;
        checks++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp0_result !== 32'd12 || rr_rsp0_zero !== 1'b0) begin
            errors++; $display("FAIL single_rsp got v%b r%0d z%b exp v1 r12 z0",
                               rr_rsp0_valid, rr_rsp0_result, rr_rsp0_zero);
        end
        checks++;
        if (rr_alu_op !== 4'd0 || rr_alu_a !== '0 || rr_alu_b !== '0) begin
            errors++; $display("FAIL idle_alu got op%0d a%0h b%0h exp 0 0 0",
                               rr_alu_op, rr_alu_a, rr_alu_b);
        end
        tick();
        checks++;
        if (rr_rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain got v%b exp v0", rr_rsp0_valid);
        end
    endtask

    task automatic test_conflict();
        logic exp0;
        apply_reset();
        req0_valid = 1; req0_op = OP_SUB; req0_a = 9;    req0_b = 9;
        req1_valid = 1; req1_op = OP_XOR; req1_a = 'hF0; req1_b = 'h0F;
        for (int k = 0; k < 4; k++) begin
            exp0 = (k % 2 == 0);
            #1;
            checks++;
            if (rr_req0_ready !== exp0 || rr_req1_ready !== !exp0) begin
                errors++; $display("FAIL conflict_grant cycle%0d got %b%b exp %b%b",
                                   k, rr_req0_ready, rr_req1_ready, exp0, !exp0);
            end
            tick();
            checks++;
            if (exp0 && (rr_rsp0_valid !== 1'b1 || rr_rsp0_result !== '0 || rr_rsp0_zero !== 1'b1
                         || rr_rsp1_valid !== 1'b0)) begin
                errors++; $display("FAIL conflict_rsp0 cycle%0d got v%b r%0h z%b v1=%b exp v1 r0 z1 v1=0",
                                   k, rr_rsp0_valid, rr_rsp0_result, rr_rsp0_zero, rr_rsp1_valid);
            end else if (!exp0 && (rr_rsp1_valid !== 1'b1 || rr_rsp1_result !== 32'hFF
                                   || rr_rsp1_zero !== 1'b0 || rr_rsp0_valid !== 1'b0)) begin
                errors++; $display("FAIL conflict_rsp1 cycle%0d got v%b r%0h z%b v0=%b exp v1 rff z0 v0=0",
                                   k, rr_rsp1_valid, rr_rsp1_result, rr_rsp1_zero, rr_rsp0_valid);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        rsp1_ready = 0;
        req1_valid = 1; req1_op = OP_ADD; req1_a = 3; req1_b = 4;
        #1;
        checks++;
        if (rr_req1_ready !== 1'b1) begin
            errors++; $display("FAIL stall_fill got rdy%b exp 1", rr_req1_ready);
        end
        tick();
        req1_op = OP_OR; req1_a = 'hA; req1_b = 'h5;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_op = OP_ADD; req0_a = i; req0_b = i + 1;
            #1;
            checks++;
            if (rr_req0_ready !== 1'b1 || rr_req1_ready !== 1'b0) begin
                errors++; $display("FAIL stall_grant cycle%0d got %b%b exp 10",
                                   i, rr_req0_ready, rr_req1_ready);
            end
            tick();
            checks++;
            if (rr_rsp1_valid !== 1'b1 || rr_rsp1_result !== 32'd7
                || rr_rsp0_valid !== 1'b1 || rr_rsp0_result !== 32'(2 * i + 1)) begin
                errors++; $display("FAIL stall_hold cycle%0d got v1=%b r1=%0d v0=%b r0=%0d exp 1 7 1 %0d",
                                   i, rr_rsp1_valid, rr_rsp1_result, rr_rsp0_valid,
                                   rr_rsp0_result, 2 * i + 1);
            end
        end
        req0_valid = 0; rsp1_ready = 1;
        #1;
        checks++;
        if (rr_req1_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got rdy%b exp 1", rr_req1_ready);
        end
        tick();
        checks++;
        if (rr_rsp1_valid !== 1'b1 || rr_rsp1_result !== 32'hF) begin
            errors++; $display("FAIL stall_release_rsp got v%b r%0h exp v1 rf", rr_rsp1_valid, rr_rsp1_result);
        end
    endtask

    task automatic test_passthrough();
        apply_reset();
        rsp0_ready = 0;
        req0_valid = 1; req0_op = OP_ADD; req0_a = 2; req0_b = 2;
        tick();
        req0_op = OP_SLTU; req0_a = 1; req0_b = 2;
        #1;
        checks++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp0_result !== 32'd4 || rr_req0_ready !== 1'b0) begin
            errors++; $display("FAIL pass_full got v%b r%0d rdy%b exp v1 r4 rdy0",
                               rr_rsp0_valid, rr_rsp0_result, rr_req0_ready);
        end
        rsp0_ready = 1;
        #1;
        checks++;
        if (rr_req0_ready !== 1'b1) begin
            errors++; $display("FAIL pass_ready got rdy%b exp 1", rr_req0_ready);
        end
        tick();
        req0_valid = 0;
        checks++;
        if (rr_rsp0_valid !== 1'b1 || rr_rsp0_result !== 32'd1 || rr_rsp0_zero !== 1'b0) begin
            errors++; $display("FAIL pass_rsp got v%b r%0d z%b exp v1 r1 z0",
                               rr_rsp0_valid, rr_rsp0_result, rr_rsp0_zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ops[3];
        logic [W-1:0] as[3];
        logic [W-1:0] bs[3];
        logic [W-1:0] exp_r[3];
        ops = '{OP_AND, OP_SLT, 4'd15};
        as  = '{32'hFF00, 32'hFFFF_FFFF, 32'd5};
        bs  = '{32'h0FF0, 32'd1, 32'd6};
        exp_r = '{32'h0F00, 32'd1, 32'd0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1; req1_op = ops[i]; req1_a = as[i]; req1_b = bs[i];
            #1;
            checks++;
            if (rr_req1_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready op%0d got %b exp 1", i, rr_req1_ready);
            end
            tick();
            checks++;
            if (rr_rsp1_valid !== 1'b1 || rr_rsp1_result !== exp_r[i]
                || rr_rsp1_zero !== (exp_r[i] == '0)) begin
                errors++; $display("FAIL b2b_rsp op%0d got v%b r%0h z%b exp v1 r%0h z%b",
                                   i, rr_rsp1_valid, rr_rsp1_result, rr_rsp1_zero,
                                   exp_r[i], (exp_r[i] == '0));
            end
        end
        req1_valid = 0;
    endtask

    task automatic test_priority();
        apply_reset();
        req0_valid = 1; req0_op = OP_ADD; req0_a = 1;  req0_b = 2;
        req1_valid = 1; req1_op = OP_ADD; req1_a = 10; req1_b = 20;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin
                errors++; $display("FAIL prio_grant cycle%0d got %b%b exp 10",
                                   k, fp_req0_ready, fp_req1_ready);
            end
            tick();
            checks++;
            if (fp_rsp0_valid !== 1'b1 || fp_rsp0_result !== 32'd3 || fp_rsp1_valid !== 1'b0) begin
                errors++; $display("FAIL prio_rsp cycle%0d got v%b r%0d v1=%b exp v1 r3 v1=0",
                                   k, fp_rsp0_valid, fp_rsp0_result, fp_rsp1_valid);
            end
        end
        req0_valid = 0;
        #1;
        checks++;
        if (fp_req1_ready !== 1'b1) begin
            errors++; $display("FAIL prio_release got rdy%b exp 1", fp_req1_ready);
        end
        tick();
        req1_valid = 0;
        checks++;
        if (fp_rsp1_valid !== 1'b1 || fp_rsp1_result !== 32'd30) begin
            errors++; $display("FAIL prio_release_rsp got v%b r%0d exp v1 r30", fp_rsp1_valid, fp_rsp1_result);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_stall();
        test_passthrough();
        test_back_to_back();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
